// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Fetches are always full-word accesses.
   localparam logic [2:0] MODE_WORD = 3'b010;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitrations the fetch requester has lost.
module arb_starve_ctr #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over increment, increment stops at the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < CW'(STARVE_MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with the saturation flag registered alongside it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sat   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat   <= (cnt_d >= CW'(STARVE_MAX));
      end
   end

endmodule : arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// load/store. Data has priority; a starvation counter forces fetch progress.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [2:0]        dm_mode,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_mode,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 4;

   state_e             state_q, state_d;
   owner_e             owner_q, owner_d;
   logic               we_q, we_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic resp;
   logic arb_ok;
   logic if_win;
   logic dm_win;
   logic starve_sat;
   logic starve_inc;
   logic starve_clr;

   // Response cycle of the outstanding access doubles as an arbitration slot.
   assign resp   = rst && (state_q == ST_BUSY) && (cnt_q == CNT_W'(MEM_LAT));
   assign arb_ok = rst && ((state_q == ST_IDLE) || resp);

   // Winner: starved fetch first, then data, then fetch.
   assign if_win = arb_ok && if_req && (starve_sat || !dm_req);
   assign dm_win = arb_ok && dm_req && !if_win;

   assign starve_inc = dm_win && if_req;
   assign starve_clr = if_win || !if_req;

   arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk(clk),
      .rst(rst),
      .inc(starve_inc),
      .clr(starve_clr),
      .sat(starve_sat)
   );

   // State, owner and latency-counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, port muxing and response routing.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mode  = '0;

      if (state_q == ST_BUSY) begin
         if (resp) begin
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (resp) begin
         if (owner_q == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
         end else begin
            dm_rvalid = 1'b1;
            dm_rdata  = we_q ? '0 : mem_rdata;
         end
      end

      if (if_win) begin
         if_gnt   = 1'b1;
         mem_req  = 1'b1;
         mem_addr = if_addr;
         mem_mode = MODE_WORD;
         state_d  = ST_BUSY;
         owner_d  = OWN_IF;
         we_d     = 1'b0;
         cnt_d    = CNT_W'(1);
      end else if (dm_win) begin
         dm_gnt    = 1'b1;
         mem_req   = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         mem_mode  = dm_mode;
         state_d   = ST_BUSY;
         owner_d   = OWN_DM;
         we_d      = dm_we;
         cnt_d     = CNT_W'(1);
      end
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [2:0]  dm_mode;
   logic        dm_gnt, dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_mode;
   logic [31:0] mem_rdata;

   logic        if1_req;
   logic [31:0] if1_addr;
   logic        if1_gnt, if1_rvalid;
   logic [31:0] if1_rdata;
   logic        dm1_gnt, dm1_rvalid;
   logic [31:0] dm1_rdata;
   logic        mem1_req, mem1_we;
   logic [31:0] mem1_addr, mem1_wdata;
   logic [2:0]  mem1_mode;
   logic [31:0] mem1_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_mode(dm_mode), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mode(mem_mode), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt),
      .if_rvalid(if1_rvalid), .if_rdata(if1_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_mode(3'b000), .dm_gnt(dm1_gnt), .dm_rvalid(dm1_rvalid), .dm_rdata(dm1_rdata),
      .mem_req(mem1_req), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
      .mem_mode(mem1_mode), .mem_rdata(mem1_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requesters must hold req until granted.
   logic if_pend, dm_pend;
   initial begin
      if_pend = 1'b0;
      dm_pend = 1'b0;
   end
   always @(posedge clk) begin
      if (rst && if_pend) assert (if_req) else $error("protocol violation: if_req dropped before if_gnt");
      if (rst && dm_pend) assert (dm_req) else $error("protocol violation: dm_req dropped before dm_gnt");
      if_pend <= rst && if_req && !if_gnt;
      dm_pend <= rst && dm_req && !dm_gnt;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_mode = 3'b010;
      mem_rdata = 32'h0;
      if1_req = 1'b0; if1_addr = 32'h0; mem1_rdata = 32'h0;

      // Reset holds every output low even with requests pending.
      next_cyc(); #1;
      check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
      check("rst_dm_gnt", {31'h0, dm_gnt}, 32'h0);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);

      next_cyc(); if_req = 1'b0; dm_req = 1'b0; rst = 1'b1;
      next_cyc();

      // Single fetch.
      next_cyc(); if_req = 1'b1; if_addr = 32'h100; #1;
      check("f_if_gnt", {31'h0, if_gnt}, 32'h1);
      check("f_mem_req", {31'h0, mem_req}, 32'h1);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_mem_we", {31'h0, mem_we}, 32'h0);
      check("f_mem_mode", {29'h0, mem_mode}, 32'h2);
      next_cyc(); if_req = 1'b0; #1;
      check("f_c1_mem_req", {31'h0, mem_req}, 32'h0);
      check("f_c1_mem_addr", mem_addr, 32'h0);
      check("f_c1_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h0050_0093; #1;
      check("f_if_rvalid", {31'h0, if_rvalid}, 32'h1);
      check("f_if_rdata", if_rdata, 32'h0050_0093);
      check("f_dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h0; #1;
      check("f_c3_if_rvalid", {31'h0, if_rvalid}, 32'h0);

      // Simultaneous requests: data first, fetch in the response cycle.
      next_cyc(); if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_mode = 3'b010; #1;
      check("b_dm_gnt", {31'h0, dm_gnt}, 32'h1);
      check("b_if_gnt", {31'h0, if_gnt}, 32'h0);
      check("b_mem_addr", mem_addr, 32'h40);
      next_cyc(); dm_req = 1'b0; #1;
      check("b_c1_if_gnt", {31'h0, if_gnt}, 32'h0);
      next_cyc(); mem_rdata = 32'h1111_2222; #1;
      check("b_dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
      check("b_dm_rdata", dm_rdata, 32'h1111_2222);
      check("b_c2_if_gnt", {31'h0, if_gnt}, 32'h1);
      check("b_c2_mem_addr", mem_addr, 32'h200);
      check("b_c2_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      next_cyc(); if_req = 1'b0; mem_rdata = 32'h0; #1;
      check("b_c3_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h3333_4444; #1;
      check("b_if_rvalid", {31'h0, if_rvalid}, 32'h1);
      check("b_if_rdata", if_rdata, 32'h3333_4444);
      check("b_c4_dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h0;

      // Starvation: both held; fetch forced through after four losses.
      dm_addr = 32'h80; if_addr = 32'h300;
      for (int c = 0; c <= 12; c++) begin
         next_cyc();
         dm_req = (c <= 10);
         if_req = 1'b1;
         #1;
         check($sformatf("stv_dm_gnt_c%0d", c), {31'h0, dm_gnt},
               (c == 0 || c == 2 || c == 4 || c == 6 || c == 10) ? 32'h1 : 32'h0);
         check($sformatf("stv_if_gnt_c%0d", c), {31'h0, if_gnt},
               (c == 8 || c == 12) ? 32'h1 : 32'h0);
      end
      next_cyc(); if_req = 1'b0;
      next_cyc();
      next_cyc();

      // Store: write strobe for the grant cycle only, ack carries zero data.
      next_cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20;
      dm_wdata = 32'hDEAD_BEEF; dm_mode = 3'b000; #1;
      check("s_dm_gnt", {31'h0, dm_gnt}, 32'h1);
      check("s_mem_we", {31'h0, mem_we}, 32'h1);
      check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("s_mem_addr", mem_addr, 32'h20);
      check("s_mem_mode", {29'h0, mem_mode}, 32'h0);
      next_cyc(); dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0; #1;
      check("s_c1_mem_we", {31'h0, mem_we}, 32'h0);
      check("s_c1_mem_wdata", mem_wdata, 32'h0);
      next_cyc(); mem_rdata = 32'hCAFE_F00D; #1;
      check("s_dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
      check("s_dm_rdata", dm_rdata, 32'h0);
      check("s_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h0;

      // Reset during an outstanding fetch discards its response.
      next_cyc(); if_req = 1'b1; if_addr = 32'h400; #1;
      check("r_if_gnt", {31'h0, if_gnt}, 32'h1);
      next_cyc(); rst = 1'b0; #1;
      check("r_c1_if_gnt", {31'h0, if_gnt}, 32'h0);
      check("r_c1_mem_req", {31'h0, mem_req}, 32'h0);
      next_cyc(); rst = 1'b1; mem_rdata = 32'h5555_5555; #1;
      check("r_c2_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      check("r_c2_if_gnt", {31'h0, if_gnt}, 32'h1);
      check("r_c2_mem_addr", mem_addr, 32'h400);
      next_cyc(); if_req = 1'b0; mem_rdata = 32'h0; #1;
      check("r_c3_if_rvalid", {31'h0, if_rvalid}, 32'h0);
      next_cyc(); mem_rdata = 32'h6666_6666; #1;
      check("r_c4_if_rvalid", {31'h0, if_rvalid}, 32'h1);
      check("r_c4_if_rdata", if_rdata, 32'h6666_6666);
      next_cyc(); mem_rdata = 32'h0;

      // MEM_LAT=1: back-to-back fetches, one per cycle.
      next_cyc(); if1_req = 1'b1; if1_addr = 32'h0; #1;
      check("l1_c0_gnt", {31'h0, if1_gnt}, 32'h1);
      check("l1_c0_addr", mem1_addr, 32'h0);
      check("l1_c0_rvalid", {31'h0, if1_rvalid}, 32'h0);
      next_cyc(); if1_addr = 32'h4; mem1_rdata = 32'hA000_0000; #1;
      check("l1_c1_gnt", {31'h0, if1_gnt}, 32'h1);
      check("l1_c1_addr", mem1_addr, 32'h4);
      check("l1_c1_rvalid", {31'h0, if1_rvalid}, 32'h1);
      check("l1_c1_rdata", if1_rdata, 32'hA000_0000);
      next_cyc(); if1_addr = 32'h8; mem1_rdata = 32'hA000_0004; #1;
      check("l1_c2_gnt", {31'h0, if1_gnt}, 32'h1);
      check("l1_c2_addr", mem1_addr, 32'h8);
      check("l1_c2_rvalid", {31'h0, if1_rvalid}, 32'h1);
      check("l1_c2_rdata", if1_rdata, 32'hA000_0004);
      next_cyc(); if1_req = 1'b0; mem1_rdata = 32'hA000_0008; #1;
      check("l1_c3_gnt", {31'h0, if1_gnt}, 32'h0);
      check("l1_c3_rvalid", {31'h0, if1_rvalid}, 32'h1);
      check("l1_c3_rdata", if1_rdata, 32'hA000_0008);
      next_cyc(); mem1_rdata = 32'h0; #1;
      check("l1_c4_rvalid", {31'h0, if1_rvalid}, 32'h0);

      next_cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter
